spi_reg_writer: RTL and testbench

- SPI controller (initiator) that drives the same 3-wire write bus our register-file SPI peripheral receives: SCLK, nCS, COPI.
- Accepts one register-write request at a time over a valid/ready handshake.
- Serialises each request as a 16-bit mode-0 frame, MSB first, and pulses done when the frame completes.
- Sits in test harnesses and in any on-chip master that configures the peripheral's enable/PWM/duty registers.

---
 rtl/spi_reg_writer.sv | 189 ++++++++++++++++++
 tb/tb_spi_reg_writer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_writer.sv
// SPI write-only initiator: serialises {rw, addr[6:0], data[7:0]} as a 16-bit mode-0 frame, MSB first.
// Optional build macro SPI_REG_WRITER_ADDR_CHECK_EN rejects addresses above 7'h04 with an err pulse.
module spi_reg_writer #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
    output logic       sclk,
    output logic       ncs,
    output logic       copi,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned MAX_CNT  = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int unsigned CNT_W    = $clog2(MAX_CNT + 1);
    localparam int unsigned FRAME_W  = 16;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [3:0]       BIT_LAST = 4'd15;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [FRAME_W-1:0]   sh_q, sh_d;
    logic                 sclk_q, sclk_d;
    logic                 ncs_q, ncs_d;
    logic                 copi_q, copi_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 ready_q, ready_d;
    logic                 accept;
    logic                 bad_addr;
    logic [FRAME_W-1:0]   frame;

    assign accept = req_valid && ready_q;
    assign frame  = {req_rw, req_addr, req_data};

`ifdef SPI_REG_WRITER_ADDR_CHECK_EN
    // A rejected request completes its handshake, then reports err one cycle later.
    logic reject_q, reject_d;
    assign bad_addr = (req_addr > 7'h04);
    assign reject_d = accept && bad_addr;
    assign err_d    = reject_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) reject_q <= 1'b0;
        else        reject_q <= reject_d;
    end
`else
    assign bad_addr = 1'b0;
    assign err_d    = 1'b0;
`endif

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            sclk_q  <= 1'b0;
            ncs_q   <= 1'b1;
            copi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            sclk_q  <= sclk_d;
            ncs_q   <= ncs_d;
            copi_q  <= copi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    // Next-state: SHIFT runs 16 full SCLK periods (high then low); copi advances on falling edges.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        sclk_d  = sclk_q;
        ncs_d   = ncs_q;
        copi_d  = copi_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept && !bad_addr) begin
                    ncs_d   = 1'b0;
                    copi_d  = frame[FRAME_W-1];
                    sh_d    = frame;
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    sclk_d  = 1'b1;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SHIFT: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        if (bit_q != BIT_LAST) begin
                            sh_d   = {sh_q[FRAME_W-2:0], 1'b0};
                            copi_d = sh_q[FRAME_W-2];
                        end
                    end else if (bit_q == BIT_LAST) begin
                        state_d = HOLD;
                    end else begin
                        sclk_d = 1'b1;
                        bit_d  = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    ncs_d   = 1'b1;
                    copi_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                sclk_d  = 1'b0;
                ncs_d   = 1'b1;
                copi_d  = 1'b0;
            end
        endcase

        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
    end

    assign req_ready = ready_q;
    assign sclk      = sclk_q;
    assign ncs       = ncs_q;
    assign copi      = copi_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_spi_reg_writer.sv
// Directed bench for spi_reg_writer: default-divider instance plus a CLK_DIV=1 instance.
module tb_spi_reg_writer;

    logic       clk;
    logic       rst_n;
    logic       req_valid, d1_valid;
    logic       req_rw;
    logic [6:0] req_addr;
    logic [7:0] req_data;
    logic       req_ready, sclk, ncs, copi, busy, done, err;
    logic       d1_ready, d1_sclk, d1_ncs, d1_copi, d1_busy, d1_done, d1_err;

    logic       sel;
    logic       m_ready, m_sclk, m_ncs, m_copi, m_done, m_err;

    int vectors;
    int errors;

    spi_reg_writer #(.CLK_DIV(4), .GAP_CYCLES(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
        .sclk(sclk), .ncs(ncs), .copi(copi), .busy(busy), .done(done), .err(err)
    );

    spi_reg_writer #(.CLK_DIV(1), .GAP_CYCLES(2)) u_div1 (
        .clk(clk), .rst_n(rst_n), .req_valid(d1_valid), .req_ready(d1_ready),
        .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
        .sclk(d1_sclk), .ncs(d1_ncs), .copi(d1_copi), .busy(d1_busy), .done(d1_done), .err(d1_err)
    );

    assign m_ready = sel ? d1_ready : req_ready;
    assign m_sclk  = sel ? d1_sclk  : sclk;
    assign m_ncs   = sel ? d1_ncs   : ncs;
    assign m_copi  = sel ? d1_copi  : copi;
    assign m_done  = sel ? d1_done  : done;
    assign m_err   = sel ? d1_err   : err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits for ready, presents one request and returns just after its accept edge.
    task automatic issue(input bit s, input logic rw, input logic [6:0] a, input logic [7:0] d);
        bit ok;
        sel = s;
        ok  = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (m_ready) begin
                ok = 1'b1;
                break;
            end
        end
        vectors++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready: got ready=%0b required 1 within 400 cycles", ok);
        end
        req_rw = rw; req_addr = a; req_data = d;
        if (s) d1_valid = 1'b1; else req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        d1_valid  = 1'b0;
    endtask

    // Observes one frame from just after T0 until ready returns; j counts edges after T0.
    task automatic watch_frame(input bit scr, output logic [15:0] frm, output int nbits,
                               output int low_cyc, output int done_at, output int done_cnt,
                               output int ready_at, output int bad, output int tog,
                               output int first_tog, output int last_tog);
        logic ps, pc;
        frm = '0; nbits = 0; low_cyc = 0; done_at = -1; done_cnt = 0; ready_at = -1;
        bad = 0; tog = 0; first_tog = -1; last_tog = -1; ps = 1'b0; pc = 1'b0;
        for (int j = 0; j < 400; j++) begin
            @(negedge clk);
            if (scr) begin
                req_addr = 7'($urandom);
                req_data = 8'($urandom);
                req_rw   = 1'($urandom);
            end
            if (m_sclk && !ps) begin
                frm = {frm[14:0], m_copi};
                nbits++;
            end
            if (m_sclk != ps) begin
                tog++;
                if (first_tog < 0) first_tog = j;
                last_tog = j;
            end
            if (!m_ncs) low_cyc++;
            if (m_done) begin
                done_cnt++;
                if (done_at < 0) done_at = j;
            end
            if (m_err) bad++;
            if (m_ncs && (m_sclk != ps)) bad++;
            if (j > 0 && (m_copi != pc) && !(ps && !m_sclk) && !m_done) bad++;
            if (m_ready) begin
                ready_at = j;
                break;
            end
            ps = m_sclk;
            pc = m_copi;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; d1_valid = 1'b0; sel = 1'b0;
        req_rw = 1'b0; req_addr = '0; req_data = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (sclk !== 1'b0)      begin errors++; $display("FAIL rst_sclk: got %b required 0", sclk); end
        vectors++; if (ncs !== 1'b1)       begin errors++; $display("FAIL rst_ncs: got %b required 1", ncs); end
        vectors++; if (copi !== 1'b0)      begin errors++; $display("FAIL rst_copi: got %b required 0", copi); end
        vectors++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
        vectors++; if (done !== 1'b0)      begin errors++; $display("FAIL rst_done: got %b required 0", done); end
        vectors++; if (err !== 1'b0)       begin errors++; $display("FAIL rst_err: got %b required 0", err); end
        vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b required 1", req_ready); end
        vectors++; if (d1_ncs !== 1'b1)    begin errors++; $display("FAIL rst_d1_ncs: got %b required 1", d1_ncs); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b required 1", req_ready); end
    endtask

    task automatic test_single_write();
        logic [15:0] f; int nb, lc, da, dc, ra, bd, tg, ft, lt;
        issue(1'b0, 1'b1, 7'h04, 8'hA5);
        watch_frame(1'b0, f, nb, lc, da, dc, ra, bd, tg, ft, lt);
        vectors++; if (f !== 16'h84A5)  begin errors++; $display("FAIL single_frame: got %h required 84a5", f); end
        vectors++; if (nb !== 16)       begin errors++; $display("FAIL single_rises: got %0d required 16", nb); end
        vectors++; if (lc !== 136)      begin errors++; $display("FAIL single_ncs_low: got %0d required 136", lc); end
        vectors++; if (da !== 136)      begin errors++; $display("FAIL single_done_at: got %0d required 136", da); end
        vectors++; if (dc !== 1)        begin errors++; $display("FAIL single_done_width: got %0d required 1", dc); end
        vectors++; if (ra + 1 !== 141)  begin errors++; $display("FAIL single_next_accept: got %0d required 141", ra + 1); end
        vectors++; if (bd !== 0)        begin errors++; $display("FAIL single_waveform: got %0d bad cycles required 0", bd); end
        vectors++; if (tg !== 32 || ft !== 4 || lt !== 128) begin
            errors++; $display("FAIL single_sclk: got tog=%0d first=%0d last=%0d required 32/4/128", tg, ft, lt);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] f; int nb, lc, da, dc, ra, bd, tg, ft, lt, gap;
        bit ok;
        sel = 1'b0;
        ok  = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        vectors++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %0b required 1", ok); end
        req_rw = 1'b1; req_addr = 7'h00; req_data = 8'hFF; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_addr = 7'h02; req_data = 8'h0F;
        watch_frame(1'b0, f, nb, lc, da, dc, ra, bd, tg, ft, lt);
        gap = ra - da + 1;
        vectors++; if (f !== 16'h80FF) begin errors++; $display("FAIL b2b_frame1: got %h required 80ff", f); end
        vectors++; if (gap < 4)        begin errors++; $display("FAIL b2b_gap: got %0d required >=4", gap); end
        vectors++; if (ra !== 140)     begin errors++; $display("FAIL b2b_gap_end: got %0d required 140", ra); end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        vectors++; if (ncs !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL b2b_accept_edge: got ncs=%b busy=%b required 0/1", ncs, busy);
        end
        watch_frame(1'b0, f, nb, lc, da, dc, ra, bd, tg, ft, lt);
        vectors++; if (f !== 16'h820F) begin errors++; $display("FAIL b2b_frame2: got %h required 820f", f); end
        vectors++; if (da !== 136)     begin errors++; $display("FAIL b2b_done2: got %0d required 136", da); end
    endtask

    task automatic test_min_divider();
        logic [15:0] f; int nb, lc, da, dc, ra, bd, tg, ft, lt;
        issue(1'b1, 1'b1, 7'h01, 8'h55);
        watch_frame(1'b0, f, nb, lc, da, dc, ra, bd, tg, ft, lt);
        vectors++; if (f !== 16'h8155) begin errors++; $display("FAIL div1_frame: got %h required 8155", f); end
        vectors++; if (lc !== 34)      begin errors++; $display("FAIL div1_ncs_low: got %0d required 34", lc); end
        vectors++; if (da !== 34)      begin errors++; $display("FAIL div1_done_at: got %0d required 34", da); end
        vectors++; if (tg !== 32 || ft !== 1 || lt !== 32) begin
            errors++; $display("FAIL div1_sclk_toggle: got tog=%0d first=%0d last=%0d required 32/1/32", tg, ft, lt);
        end
        vectors++; if (bd !== 0)       begin errors++; $display("FAIL div1_copi_edges: got %0d bad cycles required 0", bd); end
        vectors++; if (ra !== 36)      begin errors++; $display("FAIL div1_ready_at: got %0d required 36", ra); end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] f; int nb, lc, da, dc, ra, bd, tg, ft, lt;
        int rises; logic ps;
        issue(1'b0, 1'b1, 7'h03, 8'h12);
        rises = 0; ps = 1'b0;
        for (int j = 0; j < 400 && rises < 7; j++) begin
            @(negedge clk);
            if (sclk && !ps) rises++;
            ps = sclk;
        end
        vectors++; if (rises !== 7) begin errors++; $display("FAIL mid_rises: got %0d required 7", rises); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (ncs !== 1'b1 || sclk !== 1'b0 || copi !== 1'b0) begin
            errors++; $display("FAIL mid_async: got ncs=%b sclk=%b copi=%b required 1/0/0", ncs, sclk, copi);
        end
        vectors++; if (busy !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL mid_ctrl: got busy=%b done=%b ready=%b required 0/0/1", busy, done, req_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue(1'b0, 1'b1, 7'h03, 8'h12);
        watch_frame(1'b0, f, nb, lc, da, dc, ra, bd, tg, ft, lt);
        vectors++; if (f !== 16'h8312 || nb !== 16) begin
            errors++; $display("FAIL mid_refresh_frame: got %h/%0d required 8312/16", f, nb);
        end
        vectors++; if (da !== 136 || dc !== 1) begin
            errors++; $display("FAIL mid_refresh_done: got at=%0d n=%0d required 136/1", da, dc);
        end
    endtask

    task automatic test_input_stability();
        logic [15:0] f; int nb, lc, da, dc, ra, bd, tg, ft, lt;
        issue(1'b0, 1'b0, 7'h03, 8'h3C);
        watch_frame(1'b1, f, nb, lc, da, dc, ra, bd, tg, ft, lt);
        vectors++; if (f !== 16'h033C) begin errors++; $display("FAIL stable_frame: got %h required 033c", f); end
        vectors++; if (lc !== 136)     begin errors++; $display("FAIL stable_ncs_low: got %0d required 136", lc); end
    endtask

    task automatic test_addr_check();
        logic [15:0] f; int nb, lc, da, dc, ra, bd, tg, ft, lt;
`ifdef SPI_REG_WRITER_ADDR_CHECK_EN
        int errs_at1, errs_else, idle_bad;
        issue(1'b0, 1'b1, 7'h05, 8'h11);
        errs_at1 = 0; errs_else = 0; idle_bad = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (err && j == 1) errs_at1++;
            else if (err)      errs_else++;
            if (!ncs || sclk || copi || done || busy) idle_bad++;
        end
        vectors++; if (errs_at1 !== 1)  begin errors++; $display("FAIL chk_err_pulse: got %0d required 1", errs_at1); end
        vectors++; if (errs_else !== 0) begin errors++; $display("FAIL chk_err_width: got %0d required 0", errs_else); end
        vectors++; if (idle_bad !== 0)  begin errors++; $display("FAIL chk_idle: got %0d bad cycles required 0", idle_bad); end
`else
        issue(1'b0, 1'b1, 7'h05, 8'h77);
        watch_frame(1'b0, f, nb, lc, da, dc, ra, bd, tg, ft, lt);
        vectors++; if (f !== 16'h8577) begin errors++; $display("FAIL addr5_frame: got %h required 8577", f); end
        vectors++; if (bd !== 0)       begin errors++; $display("FAIL addr5_err_or_wave: got %0d bad cycles required 0", bd); end
`endif
        issue(1'b0, 1'b1, 7'h04, 8'h3E);
        watch_frame(1'b0, f, nb, lc, da, dc, ra, bd, tg, ft, lt);
        vectors++; if (f !== 16'h843E) begin errors++; $display("FAIL addr4_frame: got %h required 843e", f); end
        vectors++; if (da !== 136 || bd !== 0) begin
            errors++; $display("FAIL addr4_done: got at=%0d bad=%0d required 136/0", da, bd);
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_single_write();
        test_back_to_back();
        test_min_divider();
        test_reset_mid_frame();
        test_input_stability();
        test_addr_check();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
